// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares a single-port 256x8 data memory between the CPU port (0)
//            and the loader/DMA port (1), one access at a time.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int RR_EN      = 1,
    parameter int STARVE_LIM = 8
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       p0_req,
    input  logic       p0_we,
    input  logic [7:0] p0_addr,
    input  logic [7:0] p0_wdata,
    output logic       p0_gnt,
    output logic       p0_rvalid,

    input  logic       p1_req,
    input  logic       p1_we,
    input  logic [7:0] p1_addr,
    input  logic [7:0] p1_wdata,
    output logic       p1_gnt,
    output logic       p1_rvalid,

    output logic [7:0] rdata,

    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_read,
    output logic       mem_write,
    input  logic [7:0] mem_rdata,

    output logic       busy
);

    localparam int              c_CNT_W  = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [c_CNT_W-1:0] c_LIM = c_CNT_W'(STARVE_LIM);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RDWAIT = 2'd2;
    localparam logic [1:0] c_RDRET  = 2'd3;

    logic [1:0]         r_state,       w_state_nxt;
    logic               r_owner,       w_owner_nxt;
    logic               r_last_owner,  w_last_owner_nxt;
    logic [c_CNT_W-1:0] r_starve_cnt,  w_starve_cnt_nxt;
    logic [7:0]         r_rdata,       w_rdata_nxt;
    logic [7:0]         r_mem_addr,    w_mem_addr_nxt;
    logic [7:0]         r_mem_wdata,   w_mem_wdata_nxt;
    logic               r_mem_read,    w_mem_read_nxt;
    logic               r_mem_write,   w_mem_write_nxt;
    logic               r_p0_gnt,      w_p0_gnt_nxt;
    logic               r_p1_gnt,      w_p1_gnt_nxt;
    logic               r_p0_rvalid,   w_p0_rvalid_nxt;
    logic               r_p1_rvalid,   w_p1_rvalid_nxt;

    logic               w_any_req;
    logic               w_tie_winner;
    logic               w_winner;

    assign w_any_req = p0_req | p1_req;

    // Tie-break policy when both ports request in the same IDLE cycle
    if (RR_EN != 0) begin : g_rr
        assign w_tie_winner = ~r_last_owner;
    end else begin : g_fixed
        assign w_tie_winner = (r_starve_cnt >= c_LIM);
    end

    always_comb begin
        w_winner = 1'b0;
        if (p1_req && !p0_req) begin
            w_winner = 1'b1;
        end else if (p0_req && p1_req) begin
            w_winner = w_tie_winner;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_starve_cnt_nxt = r_starve_cnt;
        w_rdata_nxt      = r_rdata;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_mem_read_nxt   = 1'b0;
        w_mem_write_nxt  = 1'b0;
        w_p0_gnt_nxt     = 1'b0;
        w_p1_gnt_nxt     = 1'b0;
        w_p0_rvalid_nxt  = 1'b0;
        w_p1_rvalid_nxt  = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (w_any_req) begin
                    w_owner_nxt = w_winner;
                    w_state_nxt = c_ACCESS;
                    if (w_winner) begin
                        w_mem_addr_nxt  = p1_addr;
                        w_mem_wdata_nxt = p1_wdata;
                        w_mem_read_nxt  = ~p1_we;
                        w_mem_write_nxt = p1_we;
                        w_p1_gnt_nxt    = 1'b1;
                    end else begin
                        w_mem_addr_nxt  = p0_addr;
                        w_mem_wdata_nxt = p0_wdata;
                        w_mem_read_nxt  = ~p0_we;
                        w_mem_write_nxt = p0_we;
                        w_p0_gnt_nxt    = 1'b1;
                    end
                end
            end
            c_ACCESS: begin
                w_last_owner_nxt = r_owner;
                w_state_nxt      = r_mem_read ? c_RDWAIT : c_IDLE;
            end
            c_RDWAIT: begin
                // Memory read data lands one edge after the strobe was sampled
                w_rdata_nxt     = mem_rdata;
                w_p0_rvalid_nxt = ~r_owner;
                w_p1_rvalid_nxt = r_owner;
                w_state_nxt     = c_RDRET;
            end
            c_RDRET: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase

        if (!p1_req) begin
            w_starve_cnt_nxt = '0;
        end else if ((r_state == c_IDLE) && w_any_req) begin
            if (w_winner) begin
                w_starve_cnt_nxt = '0;
            end else if (r_starve_cnt < c_LIM) begin
                w_starve_cnt_nxt = r_starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_starve_cnt <= '0;
            r_rdata      <= 8'd0;
            r_mem_addr   <= 8'd0;
            r_mem_wdata  <= 8'd0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_p0_gnt     <= 1'b0;
            r_p1_gnt     <= 1'b0;
            r_p0_rvalid  <= 1'b0;
            r_p1_rvalid  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
            r_rdata      <= w_rdata_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_read   <= w_mem_read_nxt;
            r_mem_write  <= w_mem_write_nxt;
            r_p0_gnt     <= w_p0_gnt_nxt;
            r_p1_gnt     <= w_p1_gnt_nxt;
            r_p0_rvalid  <= w_p0_rvalid_nxt;
            r_p1_rvalid  <= w_p1_rvalid_nxt;
        end
    end

    assign p0_gnt    = r_p0_gnt;
    assign p1_gnt    = r_p1_gnt;
    assign p0_rvalid = r_p0_rvalid;
    assign p1_rvalid = r_p1_rvalid;
    assign rdata     = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Two arbiters (round-robin and fixed-priority) against a
//            transaction-schedule reference model and behavioural memories.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int c_LIM = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Indexed [instance][port]; instance 0 is round-robin, 1 is fixed priority
    logic       req   [2][2];
    logic       we    [2][2];
    logic [7:0] addr  [2][2];
    logic [7:0] wdat  [2][2];
    logic       gnt   [2][2];
    logic       rv    [2][2];
    logic [7:0] rdata     [2];
    logic [7:0] mem_addr  [2];
    logic [7:0] mem_wdata [2];
    logic [7:0] mem_rdata [2];
    logic       mem_read  [2];
    logic       mem_write [2];
    logic       busy      [2];

    logic [7:0] env_mem [2][256];
    logic [7:0] ref_mem [2][256];

    int         vectors     = 0;
    int         miscompares = 0;
    int         edge_n      = 0;
    int         free_at  [2];
    bit         last_own [2];
    int         starve   [2];
    logic [31:0] exp_ring [2][8];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        dmem_arbiter #(
            .RR_EN      ((gi == 0) ? 1 : 0),
            .STARVE_LIM (c_LIM)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .p0_req    (req[gi][0]),
            .p0_we     (we[gi][0]),
            .p0_addr   (addr[gi][0]),
            .p0_wdata  (wdat[gi][0]),
            .p0_gnt    (gnt[gi][0]),
            .p0_rvalid (rv[gi][0]),
            .p1_req    (req[gi][1]),
            .p1_we     (we[gi][1]),
            .p1_addr   (addr[gi][1]),
            .p1_wdata  (wdat[gi][1]),
            .p1_gnt    (gnt[gi][1]),
            .p1_rvalid (rv[gi][1]),
            .rdata     (rdata[gi]),
            .mem_addr  (mem_addr[gi]),
            .mem_wdata (mem_wdata[gi]),
            .mem_read  (mem_read[gi]),
            .mem_write (mem_write[gi]),
            .mem_rdata (mem_rdata[gi]),
            .busy      (busy[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    // Packed view: gnt0 gnt1 rv0 rv1 rd wr busy | rdata | addr | wdata
    function automatic logic [31:0] raw_vec(input int i);
        return {1'b0, gnt[i][0], gnt[i][1], rv[i][0], rv[i][1], mem_read[i],
                mem_write[i], busy[i], rdata[i], mem_addr[i], mem_wdata[i]};
    endfunction

    function automatic logic [31:0] obs_vec(input int i);
        logic [31:0] v;
        v = raw_vec(i);
        if (!(rv[i][0] | rv[i][1]))          v[23:16] = 8'd0;
        if (!(mem_read[i] | mem_write[i]))   v[15:8]  = 8'd0;
        if (!mem_write[i])                   v[7:0]   = 8'd0;
        return v;
    endfunction

    // Behavioural memory: write commits at the strobe edge, read data next cycle
    initial begin
        for (int i = 0; i < 2; i++) begin
            mem_rdata[i] = 8'd0;
            for (int k = 0; k < 256; k++) begin
                env_mem[i][k] = 8'($urandom);
                ref_mem[i][k] = env_mem[i][k];
            end
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (mem_read[i])  mem_rdata[i] <= env_mem[i][mem_addr[i]];
                if (mem_write[i]) env_mem[i][mem_addr[i]] = mem_wdata[i];
            end
        end
    end

    // Reference model: on each accepted request, schedule the whole transaction
    task automatic model_step(input int i);
        int         n;
        bit         idle, r0, r1, w, wr;
        logic [7:0] a, d;
        n    = edge_n;
        idle = (n >= free_at[i]);
        r0   = req[i][0];
        r1   = req[i][1];
        if (r0 && !r1)      w = 1'b0;
        else if (r1 && !r0) w = 1'b1;
        else if (i == 0)    w = !last_own[i];
        else                w = (starve[i] >= c_LIM);
        if (!r1) starve[i] = 0;
        else if (idle && (r0 || r1)) begin
            if (w) starve[i] = 0;
            else if (starve[i] < c_LIM) starve[i]++;
        end
        if (idle && (r0 || r1)) begin
            a  = addr[i][int'(w)];
            d  = wdat[i][int'(w)];
            wr = we[i][int'(w)];
            exp_ring[i][n % 8][30 - int'(w)] = 1'b1;
            exp_ring[i][n % 8][24]           = 1'b1;
            exp_ring[i][n % 8][15:8]         = a;
            if (wr) begin
                exp_ring[i][n % 8][25]  = 1'b1;
                exp_ring[i][n % 8][7:0] = d;
                ref_mem[i][a] = d;
                free_at[i]    = n + 2;
            end else begin
                exp_ring[i][n % 8][26]                 = 1'b1;
                exp_ring[i][(n + 1) % 8][24]           = 1'b1;
                exp_ring[i][(n + 2) % 8][24]           = 1'b1;
                exp_ring[i][(n + 2) % 8][28 - int'(w)] = 1'b1;
                exp_ring[i][(n + 2) % 8][23:16]        = ref_mem[i][a];
                free_at[i] = n + 4;
            end
            last_own[i] = w;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                free_at[i]  = 0;
                last_own[i] = 1'b1;
                starve[i]   = 0;
                for (int k = 0; k < 8; k++) exp_ring[i][k] = 32'd0;
            end
        end else begin
            edge_n++;
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                check($sformatf("reset_outputs%0d", i), raw_vec(i), 32'd0);
            end else begin
                check($sformatf("cycle%0d", i), obs_vec(i), exp_ring[i][edge_n % 8]);
                check($sformatf("rd_wr_excl%0d", i), {31'd0, mem_read[i] & mem_write[i]}, 32'd0);
                exp_ring[i][edge_n % 8] = 32'd0;
            end
        end
    end

    task automatic drop_all();
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++) req[i][p] = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy[0] || busy[1]) && t < 20);
        check("idle_timeout", {31'd0, busy[0] | busy[1]}, 32'd0);
    endtask

    task automatic new_req(input int i, input int p);
        req[i][p]  = 1'b1;
        we[i][p]   = 1'($urandom);
        addr[i][p] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
        wdat[i][p] = 8'($urandom);
    endtask

    // Same single access on both instances; read data checked against exp_rd
    task automatic access_both(input int p, input bit wr, input logic [7:0] a,
                               input logic [7:0] d, input logic [7:0] exp_rd);
        bit done [2];
        bit got  [2];
        for (int i = 0; i < 2; i++) begin
            req[i][p] = 1'b1; we[i][p] = wr; addr[i][p] = a; wdat[i][p] = d;
            done[i] = 1'b0; got[i] = 1'b0;
        end
        for (int t = 0; t < 12 && !(got[0] && got[1]); t++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (gnt[i][p] && !done[i]) begin
                    req[i][p] = 1'b0;
                    done[i]   = 1'b1;
                    if (wr) got[i] = 1'b1;
                end
                if (!wr && rv[i][p] && !got[i]) begin
                    check($sformatf("rd_data%0d", i), {24'd0, rdata[i]}, {24'd0, exp_rd});
                    got[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 2; i++)
            check($sformatf("access_done%0d", i), {31'd0, got[i]}, 32'd1);
    endtask

    int own_q [2][$];
    int rv_after_rst;

    initial begin
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++) begin
                req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = 8'd0; wdat[i][p] = 8'd0;
            end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Port 0 write, then port 1 reads it back
        access_both(0, 1'b1, 8'h05, 8'h2A, 8'h00);
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            check($sformatf("mem05_%0d", i), {24'd0, env_mem[i][8'h05]}, 32'h2A);
        wait_idle();
        access_both(1, 1'b0, 8'h05, 8'h00, 8'h2A);
        wait_idle();

        // Continuous contention: reads on instance 0, writes on instance 1
        req[0][0] = 1; we[0][0] = 0; addr[0][0] = 8'h05;
        req[0][1] = 1; we[0][1] = 0; addr[0][1] = 8'hFF;
        req[1][0] = 1; we[1][0] = 1; addr[1][0] = 8'h10; wdat[1][0] = 8'h11;
        req[1][1] = 1; we[1][1] = 1; addr[1][1] = 8'h20; wdat[1][1] = 8'h22;
        repeat (80) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (gnt[i][0]) own_q[i].push_back(0);
                if (gnt[i][1]) own_q[i].push_back(1);
            end
        end
        drop_all();
        wait_idle();
        check("rr_grant_count", {31'd0, own_q[0].size() >= 8}, 32'd1);
        check("fp_grant_count", {31'd0, own_q[1].size() >= 18}, 32'd1);
        for (int k = 0; k < 8 && k < own_q[0].size(); k++)
            check($sformatf("rr_owner%0d", k), own_q[0][k], k % 2);
        for (int k = 0; k < 18 && k < own_q[1].size(); k++)
            check($sformatf("starve_owner%0d", k), own_q[1][k], (k % 9 == 8) ? 1 : 0);

        // Reset during RDWAIT of a port 0 read
        for (int i = 0; i < 2; i++) begin
            req[i][0] = 1; we[i][0] = 0; addr[i][0] = 8'h05;
        end
        begin
            int t;
            t = 0;
            do begin @(negedge clk); t++; end while (!gnt[0][0] && t < 10);
            check("rst_pre_gnt", {31'd0, gnt[0][0] & gnt[1][0]}, 32'd1);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            check($sformatf("rst_async%0d", i), raw_vec(i), 32'd0);
        rv_after_rst = 0;
        repeat (2) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) rv_after_rst += int'(rv[i][0]) + int'(rv[i][1]);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) rv_after_rst += int'(rv[i][0]) + int'(rv[i][1]);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("regrant%0d", i), {31'd0, gnt[i][0]}, 32'd1);
            req[i][0] = 1'b0;
        end
        check("no_rvalid_after_rst", rv_after_rst, 0);
        wait_idle();

        // Top-of-range address
        access_both(0, 1'b1, 8'hFF, 8'h5A, 8'h00);
        wait_idle();
        access_both(0, 1'b0, 8'hFF, 8'h00, 8'h5A);
        wait_idle();

        // Random independent requesters on both instances
        repeat (1200) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                for (int p = 0; p < 2; p++) begin
                    if (req[i][p] && gnt[i][p]) begin
                        if ($urandom_range(0, 1) == 1) new_req(i, p);
                        else req[i][p] = 1'b0;
                    end else if (req[i][p]) begin
                        if ($urandom_range(0, 15) == 0) req[i][p] = 1'b0;
                    end else if ($urandom_range(0, 2) == 0) begin
                        new_req(i, p);
                    end
                end
        end
        drop_all();
        wait_idle();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t observed=timeout expected=finish", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
